// File: rtl/imem_ahb_slave.sv
// imem_ahb_slave: AHB-Lite instruction-memory responder on the fetch bus.
//
// Holds a word-addressed program memory and answers pipelined fetches. A legal
// read (word size, aligned, in range, not a write) returns its word after
// WAIT_STATES stall cycles. Any illegal fetch gets a two-cycle ERROR response.
// A side-band load port writes the memory in any state.
//
// Ports:
//   clk_in, rst_n_in         fetch-bus clock, async active-low reset
//   hsel_in .. hready_in     AHB-Lite address-phase inputs
//   hrdata_out               read data (registered, held until the next legal read)
//   hreadyout_out, hresp_out slave ready / response (registered)
//   prog_we_in, prog_addr_in, prog_data_in   program-load write port
module imem_ahb_slave #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         hsel_in,
    input  logic [31:0]                  haddr_in,
    input  logic [1:0]                   htrans_in,
    input  logic                         hwrite_in,
    input  logic [2:0]                   hsize_in,
    input  logic                         hready_in,
    output logic [31:0]                  hrdata_out,
    output logic                         hreadyout_out,
    output logic                         hresp_out,
    input  logic                         prog_we_in,
    input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr_in,
    input  logic [31:0]                  prog_data_in
);

    localparam int unsigned AW       = $clog2(MEM_DEPTH);
    localparam logic [31:0] MemBytes = 32'(MEM_DEPTH) << 2;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          xfer_req;
    logic          illegal;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets,
    // so the single range compare also rejects them.
    assign offset   = haddr_in - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign xfer_req = hsel_in & htrans_in[1] & hready_in;
    assign illegal  = hwrite_in | (hsize_in != 3'b010) | (haddr_in[1:0] != 2'b00) |
                      (offset >= MemBytes);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hrdata_d = hrdata_q;

        unique case (state_q)
            StIdle, StData, StErr2: begin
                // Only these states drive HREADY high, so only here can an
                // address phase complete.
                if (hready_in) begin
                    if (xfer_req) begin
                        if (illegal) begin
                            state_d = StErr1;
                        end else begin
                            hrdata_d = mem[word_idx];
                            if (WAIT_STATES == 0) begin
                                state_d = StData;
                            end else begin
                                state_d = StWait;
                                cnt_d   = 3'(WAIT_STATES);
                            end
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = StData;
                end
            end
            StErr1: begin
                state_d = StErr2;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        hreadyout_d = !((state_d == StWait) || (state_d == StErr1));
        hresp_d     = (state_d == StErr1) || (state_d == StErr2);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            hrdata_q    <= 32'h0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Memory is deliberately not reset. A fetch of the word being loaded at the
    // same edge sees the old contents (read above happens before this update).
    always_ff @(posedge clk_in) begin
        if (prog_we_in) begin
            mem[prog_addr_in] <= prog_data_in;
        end
    end

    assign hrdata_out    = hrdata_q;
    assign hreadyout_out = hreadyout_q;
    assign hresp_out     = hresp_q;

endmodule
